// File: rtl/hazard3_fetch_aligner.sv
// hazard3_fetch_aligner: word-fetch sequencer and halfword aligner in front of the decompressor.
// Define FETCH_ALIGNER_ERR_EN to track a bus-error bit per buffered halfword.
module hazard3_fetch_aligner #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          BUF_HW       = 6,
    parameter int          MAX_OUTSTD   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_gnt,
    input  logic        fetch_rvld,
    input  logic [31:0] fetch_rdata,
    input  logic        fetch_rerr,
    input  logic        jump_vld,
    input  logic [31:0] jump_target,
    output logic        instr_vld,
    input  logic        instr_rdy,
    output logic [31:0] instr_data,
    output logic        instr_is_32bit,
    output logic        instr_err
);
    localparam int LW = $clog2(BUF_HW + 1);
    localparam int BW = 16 * BUF_HW;

    logic [BW-1:0] buf_r, buf_nxt_s;
    logic [LW-1:0] level_r, level_nxt_s;
    logic [LW-1:0] wr_pos_s;
    logic [1:0]    outstd_r, outstd_nxt_s;
    logic [1:0]    discard_r, discard_nxt_s;
    logic          skip_hw_r, skip_hw_nxt_s;
    logic [31:0]   addr_r, addr_nxt_s;
    logic          req_ok_s, grant_s, accept_s, pop_s, hw0_err_s;
    logic [1:0]    pop_cnt_s, push_cnt_s;
    logic [31:0]   push_data_s;
    int            room_need_s;
    logic          unused_tgt_s;

    assign unused_tgt_s = jump_target[0];

`ifdef FETCH_ALIGNER_ERR_EN
    logic [BUF_HW-1:0] err_r, err_nxt_s;
    logic [1:0]        push_err_s;

    assign hw0_err_s  = err_r[0];
    assign instr_err  = err_r[0] | (instr_is_32bit & err_r[1]);
    assign push_err_s = accept_s ? ({~skip_hw_r, 1'b1} & {2{fetch_rerr}}) : 2'b00;

    // Error bits move in lockstep with the halfwords they describe.
    always_comb begin
        if (jump_vld) begin
            err_nxt_s = '0;
        end else begin
            err_nxt_s = (err_r >> pop_cnt_s) | (BUF_HW'(push_err_s) << wr_pos_s);
        end
    end

    // Error-bit storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= '0;
        end else begin
            err_r <= err_nxt_s;
        end
    end
`else
    logic unused_rerr_s;
    assign unused_rerr_s = fetch_rerr;
    assign hw0_err_s     = 1'b0;
    assign instr_err     = 1'b0;
`endif

    assign fetch_addr     = addr_r;
    assign instr_data     = buf_r[31:0];
    assign instr_is_32bit = (buf_r[1:0] == 2'b11);

    // A new word may be requested only if the buffer can absorb it and every word already in flight.
    always_comb begin
        room_need_s = int'(level_r) + 32'sd2 * int'(outstd_r) + 32'sd2;
        if (!jump_vld && (int'(outstd_r) < MAX_OUTSTD) && (room_need_s <= BUF_HW)) begin
            req_ok_s = 1'b1;
        end else begin
            req_ok_s = 1'b0;
        end
    end

    assign fetch_req = req_ok_s & rst_n;
    assign grant_s   = fetch_req & fetch_gnt;
    assign accept_s  = fetch_rvld & ~jump_vld & (discard_r == 2'd0);

    // Instruction is complete once both halves of a 32-bit encoding are present; a faulting hw0 goes out alone.
    always_comb begin
        if (level_r >= LW'(2'd2)) begin
            instr_vld = 1'b1;
        end else if ((level_r == LW'(2'd1)) && (!instr_is_32bit || hw0_err_s)) begin
            instr_vld = 1'b1;
        end else begin
            instr_vld = 1'b0;
        end
    end

    assign pop_s = instr_vld & instr_rdy & ~jump_vld;

    // Pop and push sizes plus the halfword(s) taken from the response word.
    always_comb begin
        if (!pop_s) begin
            pop_cnt_s = 2'd0;
        end else if (instr_is_32bit && !hw0_err_s) begin
            pop_cnt_s = 2'd2;
        end else begin
            pop_cnt_s = 2'd1;
        end
        if (!accept_s) begin
            push_cnt_s  = 2'd0;
            push_data_s = 32'h0000_0000;
        end else if (skip_hw_r) begin
            push_cnt_s  = 2'd1;
            push_data_s = {16'h0000, fetch_rdata[31:16]};
        end else begin
            push_cnt_s  = 2'd2;
            push_data_s = fetch_rdata;
        end
    end

    assign wr_pos_s = level_r - LW'(pop_cnt_s);

    // Drop popped halfwords from the bottom, append the response above whatever remains.
    always_comb begin
        if (jump_vld) begin
            buf_nxt_s   = '0;
            level_nxt_s = '0;
        end else begin
            buf_nxt_s   = (buf_r >> {pop_cnt_s, 4'b0000}) | (BW'(push_data_s) << {wr_pos_s, 4'b0000});
            level_nxt_s = wr_pos_s + LW'(push_cnt_s);
        end
    end

    // Fetch address, in-flight and discard bookkeeping; a jump redirects and marks in-flight words stale.
    always_comb begin
        outstd_nxt_s = outstd_r + {1'b0, grant_s} - {1'b0, fetch_rvld};
        if (jump_vld) begin
            addr_nxt_s    = {jump_target[31:2], 2'b00};
            skip_hw_nxt_s = jump_target[1];
            discard_nxt_s = outstd_r - {1'b0, fetch_rvld};
        end else begin
            addr_nxt_s    = grant_s ? (addr_r + 32'd4) : addr_r;
            skip_hw_nxt_s = accept_s ? 1'b0 : skip_hw_r;
            if (fetch_rvld && (discard_r != 2'd0)) begin
                discard_nxt_s = discard_r - 2'd1;
            end else begin
                discard_nxt_s = discard_r;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_r     <= '0;
            level_r   <= '0;
            outstd_r  <= 2'd0;
            discard_r <= 2'd0;
            skip_hw_r <= 1'b0;
            addr_r    <= {RESET_VECTOR[31:2], 2'b00};
        end else begin
            buf_r     <= buf_nxt_s;
            level_r   <= level_nxt_s;
            outstd_r  <= outstd_nxt_s;
            discard_r <= discard_nxt_s;
            skip_hw_r <= skip_hw_nxt_s;
            addr_r    <= addr_nxt_s;
        end
    end

endmodule
